line_mem_backend: RTL and testbench

//   Line-granular main-memory backend that sits directly downstream of the set-associative

---
 rtl/line_mem_backend.sv | 169 ++++++++++++++++
 tb/tb_line_mem_backend.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/line_mem_backend.sv
// line_mem_backend: line-granular main-memory model behind the cache.
// Serves whole-line reads (SWAP_IN) and write-backs (SWAP_OUT) after a fixed
// latency. Requests are levels held until a one-cycle gnt pulse. Completed
// transfers are counted for hit/miss studies.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   addr           line address, captured when a request is accepted
//   rd_req/wr_req  level requests (write wins when both are high)
//   wr_line        line to write, word i at index i
//   rd_line        last line read, held until the next read completes
//   gnt            one-cycle completion pulse
//   rd_cnt/wr_cnt  completed reads / writes since reset (wrap at 2^32)
module line_mem_backend #(
  parameter int unsigned LINE_ADDR_LEN = 3,
  parameter int unsigned ADDR_LEN      = 9,
  parameter int unsigned MEM_LATENCY   = 50
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [ADDR_LEN-1:0]                    addr,
  input  logic                                   rd_req,
  input  logic                                   wr_req,
  input  logic [(1<<LINE_ADDR_LEN)-1:0][31:0]    wr_line,
  output logic [(1<<LINE_ADDR_LEN)-1:0][31:0]    rd_line,
  output logic                                   gnt,
  output logic [31:0]                            rd_cnt,
  output logic [31:0]                            wr_cnt
);

  localparam int unsigned LINE_SIZE = 1 << LINE_ADDR_LEN;
  localparam int unsigned LINES     = 1 << ADDR_LEN;
  localparam int unsigned LAT_W     = 8;
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MEM_LATENCY - 1);

  typedef logic [LINE_SIZE-1:0][31:0] line_t;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_e;

  // Power-up content of a word: {line address, word index}, zero-extended.
  function automatic logic [31:0] init_word(input logic [ADDR_LEN-1:0] a,
                                            input int unsigned i);
    return 32'({a, LINE_ADDR_LEN'(i)});
  endfunction

  state_e               state_q, state_d;
  logic [ADDR_LEN-1:0]  addr_q, addr_d;
  logic                 op_wr_q, op_wr_d;
  line_t                wline_q, wline_d;
  logic [LAT_W-1:0]     lat_cnt_q, lat_cnt_d;
  line_t                rd_line_q, rd_line_d;
  logic                 gnt_q, gnt_d;
  logic [31:0]          rd_cnt_q, rd_cnt_d;
  logic [31:0]          wr_cnt_q, wr_cnt_d;

  // Array holds data XORed with the power-up pattern, so all-zero storage
  // reads back as {addr, i} without any explicit initialisation.
  line_t mem_q [LINES];
  line_t rd_dec_c;
  line_t wr_enc_c;
  logic  mem_we_c;
  logic  any_req_c;
  logic  op_req_c;

  assign any_req_c = rd_req | wr_req;
  assign op_req_c  = op_wr_q ? wr_req : rd_req;

  // Encode/decode between architectural data and stored representation.
  always_comb begin
    rd_dec_c = '0;
    wr_enc_c = '0;
    for (int unsigned i = 0; i < LINE_SIZE; i++) begin
      rd_dec_c[i] = mem_q[addr_q][i] ^ init_word(addr_q, i);
      wr_enc_c[i] = wline_q[i] ^ init_word(addr_q, i);
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; abort takes priority over completion.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (any_req_c) state_d = BUSY;
      BUSY: begin
        if (!op_req_c)              state_d = IDLE;
        else if (lat_cnt_q == '0)   state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath / output next values.
  always_comb begin
    addr_d    = addr_q;
    op_wr_d   = op_wr_q;
    wline_d   = wline_q;
    lat_cnt_d = lat_cnt_q;
    rd_line_d = rd_line_q;
    gnt_d     = 1'b0;
    rd_cnt_d  = rd_cnt_q;
    wr_cnt_d  = wr_cnt_q;
    mem_we_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req_c) begin
          addr_d    = addr;
          op_wr_d   = wr_req;
          lat_cnt_d = LAT_INIT;
          if (wr_req) wline_d = wr_line;
        end
      end
      BUSY: begin
        if (op_req_c) begin
          if (lat_cnt_q == '0) begin
            gnt_d = 1'b1;
            if (op_wr_q) begin
              mem_we_c = 1'b1;
              wr_cnt_d = wr_cnt_q + 32'd1;
            end else begin
              rd_line_d = rd_dec_c;
              rd_cnt_d  = rd_cnt_q + 32'd1;
            end
          end else begin
            lat_cnt_d = lat_cnt_q - LAT_W'(1);
          end
        end
      end
      default: ;
    endcase
  end

  // Registered datapath and outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q    <= '0;
      op_wr_q   <= 1'b0;
      wline_q   <= '0;
      lat_cnt_q <= '0;
      rd_line_q <= '0;
      gnt_q     <= 1'b0;
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
    end else begin
      addr_q    <= addr_d;
      op_wr_q   <= op_wr_d;
      wline_q   <= wline_d;
      lat_cnt_q <= lat_cnt_d;
      rd_line_q <= rd_line_d;
      gnt_q     <= gnt_d;
      rd_cnt_q  <= rd_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
    end
  end

  // Memory array is not reset; a reset cycle drops any pending write.
  always_ff @(posedge clk) begin
    if (mem_we_c && !rst) mem_q[addr_q] <= wr_enc_c;
  end

  assign rd_line = rd_line_q;
  assign gnt     = gnt_q;
  assign rd_cnt  = rd_cnt_q;
  assign wr_cnt  = wr_cnt_q;

endmodule

// File: tb/tb_line_mem_backend.sv
// Bench for line_mem_backend: directed scenarios with literal expectations and
// a transaction-level reference model compared against the DUT every cycle.
module tb_line_mem_backend;

  localparam int unsigned LAT = 4;
  typedef logic [7:0][31:0] line_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [8:0]  addr;
  logic        rd_req;
  logic        wr_req;
  line_t       wr_line;
  line_t       rd_line;
  logic        gnt;
  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;

  int cyc    = 0;
  int errors = 0;
  int checks = 0;

  line_mem_backend #(
    .LINE_ADDR_LEN(3),
    .ADDR_LEN     (9),
    .MEM_LATENCY  (LAT)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .addr   (addr),
    .rd_req (rd_req),
    .wr_req (wr_req),
    .wr_line(wr_line),
    .rd_line(rd_line),
    .gnt    (gnt),
    .rd_cnt (rd_cnt),
    .wr_cnt (wr_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic line_t mk_line(input logic [31:0] base);
    line_t l;
    for (int i = 0; i < 8; i++) l[i] = base + 32'(i);
    return l;
  endfunction

  // Reference model: transaction-level, completion derived from accept cycle.
  logic [31:0] m_mem [512][8];
  bit          m_on, m_pend, m_cool, m_wr, m_gnt, m_gnt_n, m_req;
  int          m_start;
  logic [8:0]  m_addr;
  line_t       m_line, m_rd_line;
  logic [31:0] m_rd_cnt, m_wr_cnt;

  initial begin
    for (int a = 0; a < 512; a++)
      for (int i = 0; i < 8; i++) m_mem[a][i] = 32'((a << 3) | i);
  end

  always @(negedge clk) begin
    if (m_on) begin
      chk("mon_gnt",     256'(gnt),    256'(m_gnt));
      chk("mon_rd_cnt",  256'(rd_cnt), 256'(m_rd_cnt));
      chk("mon_wr_cnt",  256'(wr_cnt), 256'(m_wr_cnt));
      chk("mon_rd_line", 256'(rd_line), 256'(m_rd_line));
    end
    m_gnt_n = 1'b0;
    if (rst) begin
      m_pend = 1'b0; m_cool = 1'b0; m_rd_line = '0; m_rd_cnt = '0; m_wr_cnt = '0;
    end else if (m_cool) begin
      m_cool = 1'b0;
    end else if (m_pend) begin
      m_req = m_wr ? wr_req : rd_req;
      if (!m_req) begin
        m_pend = 1'b0;
      end else if (cyc == m_start + int'(LAT)) begin
        if (m_wr) begin
          for (int i = 0; i < 8; i++) m_mem[m_addr][i] = m_line[i];
          m_wr_cnt = m_wr_cnt + 32'd1;
        end else begin
          for (int i = 0; i < 8; i++) m_rd_line[i] = m_mem[m_addr][i];
          m_rd_cnt = m_rd_cnt + 32'd1;
        end
        m_gnt_n = 1'b1; m_pend = 1'b0; m_cool = 1'b1;
      end
    end else if (rd_req || wr_req) begin
      m_pend = 1'b1; m_start = cyc; m_wr = wr_req; m_addr = addr; m_line = wr_line;
    end
    m_gnt = m_gnt_n;
    if (rst) m_on = 1'b1;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  // Issue a request, disturb addr/wr_line after capture, wait for gnt.
  task automatic do_req(input bit wr, input bit rd, input logic [8:0] a,
                        input logic [8:0] a_late, input line_t l, output int gcyc);
    int c0;
    c0 = cyc; addr = a; wr_line = l; wr_req = wr; rd_req = rd; gcyc = -1;
    for (int k = 0; k < int'(LAT) + 8 && gcyc < 0; k++) begin
      tick(1);
      if (k == 0) begin
        addr = a_late;
        wr_line = ~l;
      end
      if (gnt === 1'b1) gcyc = cyc;
    end
    wr_req = 1'b0; rd_req = 1'b0;
    chk("gnt_seen", 256'(gcyc >= 0), 256'(1));
    chk("gnt_latency", 256'(gcyc - c0), 256'(LAT + 1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int g, g1, g2;
    rst = 1'b1; addr = '0; rd_req = 1'b0; wr_req = 1'b0; wr_line = '0;
    tick(2);
    rst = 1'b0;
    chk("rst_gnt",     256'(gnt),     256'(0));
    chk("rst_rd_cnt",  256'(rd_cnt),  256'(0));
    chk("rst_wr_cnt",  256'(wr_cnt),  256'(0));
    chk("rst_rd_line", 256'(rd_line), 256'(0));

    // 1: read of line 5 after reset
    do_req(1'b0, 1'b1, 9'h005, 9'h005, '0, g);
    chk("t1_rd_line", 256'(rd_line), 256'(mk_line(32'h28)));
    chk("t1_rd_cnt",  256'(rd_cnt),  256'(32'd1));
    tick(1);
    chk("t1_gnt_one_cycle", 256'(gnt), 256'(0));

    // 2: write then read back line 0x1FF
    do_reset();
    do_req(1'b1, 1'b0, 9'h1FF, 9'h1FF, mk_line(32'hA0), g1);
    tick(2);
    do_req(1'b0, 1'b1, 9'h1FF, 9'h1FF, '0, g2);
    chk("t2_rd_line", 256'(rd_line), 256'(mk_line(32'hA0)));
    chk("t2_wr_cnt",  256'(wr_cnt),  256'(32'd1));
    chk("t2_rd_cnt",  256'(rd_cnt),  256'(32'd1));
    chk("t2_gnt_gap", 256'(g2 - g1 >= int'(LAT) + 3), 256'(1));

    // 3: read aborted after two BUSY cycles
    tick(1);
    addr = 9'h002; rd_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick(1);
      chk("t3_busy_no_gnt", 256'(gnt), 256'(0));
    end
    rd_req = 1'b0;
    tick(1);
    chk("t3_abort_no_gnt", 256'(gnt),     256'(0));
    chk("t3_rd_cnt",       256'(rd_cnt),  256'(32'd1));
    chk("t3_rd_line_held", 256'(rd_line), 256'(mk_line(32'hA0)));
    do_req(1'b0, 1'b1, 9'h003, 9'h003, '0, g);
    chk("t3_next_rd_line", 256'(rd_line), 256'(mk_line(32'h18)));
    chk("t3_next_rd_cnt",  256'(rd_cnt),  256'(32'd2));

    // 4: simultaneous read and write -> write wins
    tick(1);
    do_reset();
    do_req(1'b1, 1'b1, 9'h003, 9'h003, mk_line(32'h5500_0000), g);
    chk("t4_wr_cnt",  256'(wr_cnt),  256'(32'd1));
    chk("t4_rd_cnt",  256'(rd_cnt),  256'(32'd0));
    chk("t4_rd_line", 256'(rd_line), 256'(0));
    tick(1);
    do_req(1'b0, 1'b1, 9'h003, 9'h003, '0, g);
    chk("t4_readback", 256'(rd_line), 256'(mk_line(32'h5500_0000)));

    // 5: reset in the middle of a pending write to line 7
    tick(1);
    do_reset();
    addr = 9'h007; wr_line = mk_line(32'hDEAD_0000); wr_req = 1'b1;
    tick(2);
    chk("t5_busy_no_gnt", 256'(gnt), 256'(0));
    rst = 1'b1;
    tick(1);
    rst = 1'b0; wr_req = 1'b0;
    chk("t5_wr_cnt", 256'(wr_cnt), 256'(32'd0));
    for (int k = 0; k < 6; k++) begin
      tick(1);
      chk("t5_no_gnt", 256'(gnt), 256'(0));
    end
    do_req(1'b0, 1'b1, 9'h007, 9'h007, '0, g);
    chk("t5_line_intact", 256'(rd_line), 256'(mk_line(32'h38)));
    chk("t5_rd_cnt",      256'(rd_cnt),  256'(32'd1));
    chk("t5_wr_cnt_end",  256'(wr_cnt),  256'(32'd0));

    // 6: address changed while BUSY -> captured address used
    tick(1);
    do_req(1'b0, 1'b1, 9'h010, 9'h0AA, '0, g);
    chk("t6_rd_line", 256'(rd_line), 256'(mk_line(32'h80)));
    chk("t6_rd_cnt",  256'(rd_cnt),  256'(32'd2));
    tick(1);
    do_req(1'b0, 1'b1, 9'h0AA, 9'h0AA, '0, g);
    chk("t6_other_line", 256'(rd_line), 256'(mk_line(32'h550)));

    tick(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
